// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the three handshake groups around the memory arbiter: the
// instruction-fetch port, the data (memory-stage) port and the external
// memory port, plus the arbiter's status outputs.
//
// Signals:
//   if_req, if_addr       fetch read request and address (requester -> arbiter)
//   if_rdata, if_ack      fetch read data and completion pulse (arbiter -> requester)
//   d_req, d_we, d_addr,
//   d_wdata               data request, write enable, address, write data
//   d_rdata, d_ack        data read result and completion pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata   external memory request (arbiter -> memory)
//   mem_rdata, mem_ack    external memory response (memory -> arbiter)
//   bus_err               transaction was aborted by the watchdog
//   grant_data            owner of the current/last transaction (1 = data)
//
// Modports:
//   master  the arbiter's view
//   slave   the view of the requesters and the memory around it
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        bus_err;
  logic        grant_data;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, bus_err, grant_data
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, bus_err, grant_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one external memory port between instruction fetch and the memory
// stage. One transaction is in flight at a time; read data and a one-cycle
// ack are routed back to the owner. Data wins contention unless it has
// already been granted DATA_STREAK times in a row while fetch was waiting.
// A watchdog aborts a transaction after TIMEOUT cycles without mem_ack
// (TIMEOUT = 0 disables it) and flags bus_err together with the ack.
// All outputs are registered.
//
// Parameters:
//   DATA_STREAK  max consecutive data grants while fetch waits (1..15)
//   TIMEOUT      BUSY cycles without mem_ack before abort, 0 = off (0..65535)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    mem_arbiter_if.master: fetch port, data port, memory port, status
module mem_arbiter #(
  parameter int unsigned DATA_STREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam logic [3:0]  STREAK_MAX = 4'(DATA_STREAK);
  localparam logic [15:0] TMO_LIMIT  = 16'(TIMEOUT);
  localparam bit          TMO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        memReq_q, memReq_d;
  logic        memWe_q, memWe_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic        grantData_q, grantData_d;
  logic        ifAck_q, ifAck_d;
  logic [31:0] ifRdata_q, ifRdata_d;
  logic        dAck_q, dAck_d;
  logic [31:0] dRdata_q, dRdata_d;
  logic        busErr_q, busErr_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] tmo_q, tmo_d;

  logic        pickData;
  logic [15:0] tmoInc;

  always_comb begin
    state_d     = state_q;
    memReq_d    = memReq_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    grantData_d = grantData_q;
    ifAck_d     = ifAck_q;
    ifRdata_d   = ifRdata_q;
    dAck_d      = dAck_q;
    dRdata_d    = dRdata_q;
    busErr_d    = busErr_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    tmoInc      = tmo_q + 16'd1;
    // Data wins unless fetch is also waiting and data has used up its streak.
    pickData    = bus.d_req && !(bus.if_req && (streak_q == STREAK_MAX));

    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grantData_d = pickData;
          memReq_d    = 1'b1;
          memWdata_d  = bus.d_wdata;
          tmo_d       = 16'd0;
          state_d     = BUSY;
          if (pickData) begin
            memAddr_d = bus.d_addr;
            memWe_d   = bus.d_we;
            // The streak only grows while fetch is actually being held off.
            if (bus.if_req) begin
              streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
            end else begin
              streak_d = 4'd0;
            end
          end else begin
            memAddr_d = bus.if_addr;
            memWe_d   = 1'b0;
            streak_d  = 4'd0;
          end
        end
      end

      BUSY: begin
        if (bus.mem_ack) begin
          // A real ack beats a watchdog expiring on the same edge.
          memReq_d = 1'b0;
          busErr_d = 1'b0;
          state_d  = COOL;
          if (grantData_q) begin
            dAck_d = 1'b1;
            if (!memWe_q) begin
              dRdata_d = bus.mem_rdata;
            end
          end else begin
            ifAck_d   = 1'b1;
            ifRdata_d = bus.mem_rdata;
          end
        end else begin
          tmo_d = tmoInc;
          if (TMO_EN && (tmoInc == TMO_LIMIT)) begin
            memReq_d = 1'b0;
            busErr_d = 1'b1;
            state_d  = COOL;
            if (grantData_q) begin
              dAck_d   = 1'b1;
              dRdata_d = 32'd0;
            end else begin
              ifAck_d   = 1'b1;
              ifRdata_d = 32'd0;
            end
          end
        end
      end

      COOL: begin
        // One dead cycle so the requester can drop its request before the
        // next arbitration; otherwise a finished request would be re-granted.
        ifAck_d  = 1'b0;
        dAck_d   = 1'b0;
        busErr_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= 32'd0;
      memWdata_q  <= 32'd0;
      grantData_q <= 1'b0;
      ifAck_q     <= 1'b0;
      ifRdata_q   <= 32'd0;
      dAck_q      <= 1'b0;
      dRdata_q    <= 32'd0;
      busErr_q    <= 1'b0;
      streak_q    <= 4'd0;
      tmo_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      memReq_q    <= memReq_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      grantData_q <= grantData_d;
      ifAck_q     <= ifAck_d;
      ifRdata_q   <= ifRdata_d;
      dAck_q      <= dAck_d;
      dRdata_q    <= dRdata_d;
      busErr_q    <= busErr_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.mem_req    = memReq_q;
  assign bus.mem_we     = memWe_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_wdata  = memWdata_q;
  assign bus.grant_data = grantData_q;
  assign bus.if_ack     = ifAck_q;
  assign bus.if_rdata   = ifRdata_q;
  assign bus.d_ack      = dAck_q;
  assign bus.d_rdata    = dRdata_q;
  assign bus.bus_err    = busErr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Random fetch/data requesters and a random-latency memory drive the arbiter.
// A transaction-level reference model (memory contents, streak count, cycle
// budget per transaction) predicts every output each cycle.
module tb_mem_arbiter;

   localparam int DS = 4;
   localparam int TO = 8;

   logic clk;
   logic reset;

   mem_arbiter_if bus();

   mem_arbiter #(.DATA_STREAK(DS), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   // reference model state
   bit          mBusy;
   bit          mOwnerData;
   bit          mWe;
   int          mCnt;
   int          freeAt;
   int          streak;
   int          edgeNum;
   logic [31:0] mAddr;
   logic [31:0] mWdata;
   logic [31:0] expIfRdata;
   logic [31:0] expDRdata;
   logic [31:0] expMemAddr;
   logic [31:0] expMemWdata;
   bit          expMemWe;
   bit          expGrant;
   bit          wdataKnown;
   logic [31:0] refMem [logic [31:0]];

   // memory agent state
   logic [31:0] memArr [logic [31:0]];
   bit          memActive;
   int          memCycle;
   int          memLat;
   bit          memAckWrite;
   logic [31:0] memWAddr;
   logic [31:0] memWData;

   // request rates in percent
   int pIf;
   int pD;

   // counts a comparison and reports it when it differs
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
   endtask

   function automatic logic [31:0] initWord(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : initWord(a);
   endfunction

   function automatic logic [31:0] memRead(input logic [31:0] a);
      return memArr.exists(a) ? memArr[a] : initWord(a);
   endfunction

   function automatic int pickLatency();
      int r;
      r = $urandom_range(0, 99);
      if (r < 65)      return $urandom_range(1, 3);
      else if (r < 82) return $urandom_range(4, TO - 1);
      else if (r < 90) return TO;
      else             return TO + 4;
   endfunction

   // everything the arbiter and memory hold is lost on reset
   task automatic resetModel();
      mBusy       = 1'b0;
      mCnt        = 0;
      freeAt      = 0;
      streak      = 0;
      expIfRdata  = 32'd0;
      expDRdata   = 32'd0;
      expMemAddr  = 32'd0;
      expMemWdata = 32'd0;
      expMemWe    = 1'b0;
      expGrant    = 1'b0;
      wdataKnown  = 1'b1;
      memActive   = 1'b0;
      memAckWrite = 1'b0;
      bus.mem_ack = 1'b0;
   endtask

   task automatic checkZero(input string tag);
      checkOutput({tag, "_memReq"},    32'(bus.mem_req),    32'd0);
      checkOutput({tag, "_memWe"},     32'(bus.mem_we),     32'd0);
      checkOutput({tag, "_memAddr"},   bus.mem_addr,        32'd0);
      checkOutput({tag, "_memWdata"},  bus.mem_wdata,       32'd0);
      checkOutput({tag, "_ifAck"},     32'(bus.if_ack),     32'd0);
      checkOutput({tag, "_dAck"},      32'(bus.d_ack),      32'd0);
      checkOutput({tag, "_ifRdata"},   bus.if_rdata,        32'd0);
      checkOutput({tag, "_dRdata"},    bus.d_rdata,         32'd0);
      checkOutput({tag, "_busErr"},    32'(bus.bus_err),    32'd0);
      checkOutput({tag, "_grantData"}, 32'(bus.grant_data), 32'd0);
   endtask

   // requesters and memory decide what they drive for the coming cycle
   task automatic applyStimulus();
      if (bus.if_ack) begin
         bus.if_req = 1'b0;
      end else if (!bus.if_req && ($urandom_range(0, 99) < pIf)) begin
         bus.if_req  = 1'b1;
         bus.if_addr = 32'($urandom_range(0, 15)) << 2;
      end

      if (bus.d_ack) begin
         bus.d_req = 1'b0;
      end else if (!bus.d_req && ($urandom_range(0, 99) < pD)) begin
         bus.d_req   = 1'b1;
         bus.d_we    = 1'($urandom_range(0, 1));
         bus.d_addr  = 32'($urandom_range(0, 15)) << 2;
         bus.d_wdata = $urandom();
      end

      if (bus.mem_req) begin
         if (!memActive) begin
            memActive = 1'b1;
            memCycle  = 0;
            memLat    = pickLatency();
         end
         memCycle++;
         if (memCycle == memLat) begin
            bus.mem_ack = 1'b1;
            if (bus.mem_we) begin
               memAckWrite   = 1'b1;
               memWAddr      = bus.mem_addr;
               memWData      = bus.mem_wdata;
               bus.mem_rdata = $urandom();
            end else begin
               bus.mem_rdata = memRead(bus.mem_addr);
            end
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom();
         end
      end else begin
         memActive     = 1'b0;
         bus.mem_ack   = ($urandom_range(0, 99) < 15);
         bus.mem_rdata = $urandom();
      end
   endtask

   // one clock: sample inputs seen at the edge, advance model, compare, drive
   task automatic stepCycle();
      bit          sIf, sD, sAck, sDWe;
      logic [31:0] sIfAddr, sDAddr, sDWdata;
      bit          done, err, pickData;
      bit          expIfAck, expDAck, expErr;

      @(posedge clk);
      #1;
      edgeNum++;
      sIf     = bus.if_req;
      sIfAddr = bus.if_addr;
      sD      = bus.d_req;
      sDWe    = bus.d_we;
      sDAddr  = bus.d_addr;
      sDWdata = bus.d_wdata;
      sAck    = bus.mem_ack;

      if (memAckWrite) begin
         memArr[memWAddr] = memWData;
         memAckWrite = 1'b0;
      end

      expIfAck = 1'b0;
      expDAck  = 1'b0;
      expErr   = 1'b0;
      if (mBusy) begin
         done = 1'b0;
         err  = 1'b0;
         if (sAck) begin
            done = 1'b1;
         end else begin
            mCnt++;
            if (mCnt == TO) begin
               done = 1'b1;
               err  = 1'b1;
            end
         end
         if (done) begin
            mBusy  = 1'b0;
            freeAt = edgeNum + 2;
            expErr = err;
            if (mOwnerData) begin
               expDAck = 1'b1;
               if (err)      expDRdata = 32'd0;
               else if (mWe) refMem[mAddr] = mWdata;
               else          expDRdata = refRead(mAddr);
            end else begin
               expIfAck   = 1'b1;
               expIfRdata = err ? 32'd0 : refRead(mAddr);
            end
         end
      end else if ((edgeNum >= freeAt) && (sIf || sD)) begin
         pickData = sD && !(sIf && (streak == DS));
         if (pickData) streak = sIf ? ((streak < DS) ? streak + 1 : DS) : 0;
         else          streak = 0;
         mBusy      = 1'b1;
         mCnt       = 0;
         mOwnerData = pickData;
         mAddr      = pickData ? sDAddr : sIfAddr;
         mWe        = pickData && sDWe;
         mWdata     = sDWdata;
         expGrant   = pickData;
         expMemAddr = mAddr;
         expMemWe   = mWe;
         wdataKnown = pickData;
         if (pickData) expMemWdata = sDWdata;
      end

      checkOutput("memReq",    32'(bus.mem_req),    32'(mBusy));
      checkOutput("ifAck",     32'(bus.if_ack),     32'(expIfAck));
      checkOutput("dAck",      32'(bus.d_ack),      32'(expDAck));
      checkOutput("busErr",    32'(bus.bus_err),    32'(expErr));
      checkOutput("ifRdata",   bus.if_rdata,        expIfRdata);
      checkOutput("dRdata",    bus.d_rdata,         expDRdata);
      checkOutput("grantData", 32'(bus.grant_data), 32'(expGrant));
      checkOutput("memAddr",   bus.mem_addr,        expMemAddr);
      checkOutput("memWe",     32'(bus.mem_we),     32'(expMemWe));
      if (wdataKnown) checkOutput("memWdata", bus.mem_wdata, expMemWdata);

      applyStimulus();
   endtask

   // waits for a transaction in flight, then pulls reset between edges
   task automatic resetMidTransaction(input string tag);
      int guard;
      guard = 0;
      while (!mBusy && (guard < 200)) begin
         stepCycle();
         guard++;
      end
      checkOutput({tag, "_reachBusy"}, 32'(mBusy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkZero(tag);
      resetModel();
      @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   initial begin
      reset         = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'd0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = 32'd0;
      bus.d_wdata   = 32'd0;
      bus.mem_rdata = 32'd0;
      edgeNum       = 0;
      memCycle      = 0;
      memLat        = 1;
      memWAddr      = 32'd0;
      memWData      = 32'd0;
      mOwnerData    = 1'b0;
      mWe           = 1'b0;
      mAddr         = 32'd0;
      mWdata        = 32'd0;
      resetModel();

      #3;
      checkZero("por");
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;

      pIf = 30;
      pD  = 30;
      repeat (600) stepCycle();
      resetMidTransaction("rst1");

      pIf = 100;
      pD  = 100;
      repeat (300) stepCycle();
      resetMidTransaction("rst2");

      pIf = 60;
      pD  = 50;
      repeat (600) stepCycle();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between instruction fetch and the memory stage. Each requester uses a hold-until-ack handshake. The arbiter issues one transaction at a time and routes read data and the completion pulse back to the owner. Data accesses have priority, a streak limit prevents fetch starvation, and a watchdog aborts transactions that memory never acknowledges.

## Interface
Parameters:
- DATA_STREAK, 4: maximum consecutive data grants while fetch is waiting; range 1..15.
- TIMEOUT, 255: BUSY cycles without `mem_ack` before abort; 0 disables the watchdog; range 0..65535.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held high until `if_ack`.
- if_addr  in  32  fetch address; stable while `if_req` is high.
- if_rdata  out  32  fetch read data; valid while `if_ack` is high.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until `d_ack`.
- d_we  in  1  1 = write, 0 = read; stable while `d_req` is high.
- d_addr  in  32  data address.
- d_wdata  in  32  data to write.
- d_rdata  out  32  data read result; valid while `d_ack` is high.
- d_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request; level, held until ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; sampled when `mem_ack` is high.
- mem_ack  in  1  memory completion; ignored outside BUSY.
- bus_err  out  1  high together with the port ack when the transaction timed out.
- grant_data  out  1  owner of the current or last transaction: 1 = data, 0 = fetch.

## Operation
- All outputs are registered. While `reset` is low, every output is 0, state is IDLE, and the streak and timeout counters are 0.
- IDLE, no request pending: stay in IDLE.
- IDLE, one or both requests pending:
  - If only one port requests, grant it.
  - If both request, grant data unless streak == DATA_STREAK; in that case grant fetch.
  - On grant: latch owner, addr, we (forced to 0 for fetch) and wdata into the mem_* outputs, set `mem_req`=1, clear the timeout counter, go to BUSY.
- Streak counter:
  - On a data grant with `if_req` high: streak+1, saturating at DATA_STREAK.
  - On a data grant with `if_req` low: streak=0.
  - On a fetch grant: streak=0.
- BUSY, `mem_ack` high:
  - `mem_req`<=0.
  - Owner's ack<=1.
  - Owner's rdata<=`mem_rdata` for a read; unchanged for a write.
  - `bus_err`<=0; go to COOL.
- BUSY, `mem_ack` low:
  - Timeout counter +1.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT: `mem_req`<=0, owner's ack<=1, owner's rdata<=0, `bus_err`<=1, go to COOL.
- COOL: clear both acks and `bus_err`, go to IDLE. This unconditional cycle lets the requester drop its request, so a stale request is never re-granted.
- `mem_addr`, `mem_wdata`, `mem_we` and `grant_data` hold their values until the next grant.
- Requesters must not change addr, data or we while their req is high. Deasserting req before ack is illegal; the transaction still completes.

## Timing
- Request sampled high at edge G → `mem_req` high after G.
- Memory acks combinationally in the same cycle → ack sampled at G+1 → port ack high for the single cycle after G+1.
- Minimum request-to-ack latency is 2 cycles; general latency is 1 + (cycles until `mem_ack`).
- Port ack high after edge A → COOL at A, IDLE at A+1, earliest next grant at edge A+2. Peak throughput is one transaction per 3 cycles.
- `mem_ack` and timeout expiring on the same edge: the ack wins, `bus_err`=0, real data is returned.
- Both ports newly requesting on the same edge: arbitration follows the streak rule; the loser keeps waiting with its req high.
- `reset` low mid-transaction: all outputs go to 0 immediately (asynchronously), and the memory transaction is abandoned. The memory must also be reset.
- Streak counter width is 4 bits. The timeout counter is 16 bits and compares for equality with TIMEOUT.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x100, memory acks the cycle after `mem_req` with 0xDEADBEEF → `mem_addr`=0x100, `mem_we`=0; one-cycle `if_ack` with `if_rdata`=0xDEADBEEF; `grant_data`=0.
- **Write then read:** data write 0x200←0x12345678, then data read of 0x200 → `mem_we`=1 then 0, `mem_wdata`=0x12345678; `d_ack` pulses twice, each after its ack; 3-cycle spacing between the two `mem_req` rises.
- **Contention:** `if_req` and `d_req` both held with back-to-back data requests and DATA_STREAK=4 → grant order data, data, data, data, fetch, data; streak resets after the fetch grant.
- **Timeout:** TIMEOUT=8, memory never acks → `mem_req` is high for exactly 8 cycles, then drops; `d_ack`=1, `bus_err`=1, `d_rdata`=0 for one cycle. A repeat run with `mem_ack` on cycle 8 gives `bus_err`=0 and real data.
- **Reset mid-transaction:** `reset` low during BUSY → `mem_req`, acks and `bus_err` go to 0 before the next edge. After release, IDLE grants the pending request normally.
- **Stray ack:** `mem_ack` pulsed while in IDLE or COOL → no port ack and no state change.
